// File: rtl/test_pattern_gen_pkg.sv
// Shared video constants for the test pattern generator: pattern mode
// encodings, colour-bar/checkerboard geometry and the bounce direction type.
package test_pattern_gen_pkg;

  localparam int MODE_W    = 3;
  localparam int BAR_COUNT = 8;
  localparam int CHECK_BIT = 5;

  localparam logic [MODE_W-1:0] MODE_GRAD   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SOLID  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BARS   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_CHECK  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } bounce_dir_e;

endpackage

// File: rtl/test_pattern_gen_pattern_color.sv
// Combinational colour lookup: maps pixel position, frame count and bounce
// level to an {r,g,b} word for the selected pattern mode.
module pattern_color
  import test_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int CW       = 6,
  parameter int FW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic [XW-1:0]     i_x,
  input  logic [YW-1:0]     i_y,
  input  logic [FW-1:0]     i_frame,
  input  logic [CW-1:0]     i_lvl,
  input  logic [MODE_W-1:0] i_mode,
  output logic [3*CW-1:0]   o_rgb
);

  localparam int AW = CW + 2;
  localparam logic [CW-1:0] ONES = '1;
  localparam logic [CW-1:0] ZERO = '0;

  logic [CW-1:0] grad_r, grad_g, grad_b;
  logic [2:0]    bar;
  logic          chk;

  always_comb begin
    // Gradient channels are formed two bits wider, then wrapped to CW bits.
    grad_r = CW'(AW'(ONES) - AW'(i_frame));
    grad_g = CW'(AW'(i_y) + (AW'(i_frame) << 1));
    grad_b = CW'(AW'(i_frame));
    bar    = 3'((32'(i_x) * BAR_COUNT) / H_ACTIVE);
    chk    = |((32'(i_x) ^ 32'(i_y)) & (32'd1 << CHECK_BIT));

    o_rgb = '0;
    case (i_mode)
      MODE_GRAD:   o_rgb = {grad_r, grad_g, grad_b};
      MODE_SOLID:  o_rgb = {ONES, ONES, ONES};
      MODE_BARS:   o_rgb = {bar[2] ? ONES : ZERO, bar[1] ? ONES : ZERO, bar[0] ? ONES : ZERO};
      MODE_CHECK:  o_rgb = chk ? {ONES, ONES, ONES} : '0;
      MODE_BOUNCE: o_rgb = {i_lvl, i_lvl, i_lvl};
      default:     o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Streaming test pattern source: pixel/line/frame counters with ready/enable
// handshake, per-frame mode latch, bounce level FSM and registered colour.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_STEP   = 2,
  parameter int CW       = 6,
  parameter int FW       = 8,
  localparam int XW      = $clog2(H_ACTIVE),
  localparam int YW      = $clog2(V_ACTIVE)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_rdy,
  output logic [CW-1:0]     o_r,
  output logic [CW-1:0]     o_g,
  output logic [CW-1:0]     o_b,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic [FW-1:0]     o_frame,
  output logic              o_sof,
  output logic [MODE_W-1:0] o_mode
);

  localparam logic [XW-1:0]   X_LAST  = XW'(H_ACTIVE - X_STEP);
  localparam logic [XW-1:0]   X_INC   = XW'(X_STEP);
  localparam logic [YW-1:0]   Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0]   LVL_MAX = '1;
  // Gradient colour of pixel (0,0) in frame 0: red full, green and blue zero.
  localparam logic [3*CW-1:0] RGB_RST = {LVL_MAX, {(2*CW){1'b0}}};

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CW-1:0]     lvl_q, lvl_d;
  bounce_dir_e       dir_q, dir_d;
  logic [3*CW-1:0]   rgb_q, rgb_d;
  logic              sof_q, sof_d;
  logic              en_q, en_d;
  logic              advance, line_end, frame_wrap;

  always_comb begin
    advance    = i_en & i_rdy;
    line_end   = (x_q == X_LAST);
    frame_wrap = advance & line_end & (y_q == Y_LAST);
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    if (advance) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + X_INC;
      end
    end
    if (frame_wrap) begin
      frame_d = frame_q + 1'b1;
      mode_d  = i_mode;
    end
    sof_d = (x_d == '0) && (y_d == '0);
    en_d  = i_en;
  end

  // Bounce level: endpoints are held for one extra frame while turning.
  always_comb begin
    dir_d = dir_q;
    lvl_d = lvl_q;
    if (frame_wrap) begin
      case (dir_q)
        DIR_UP:   if (lvl_q == LVL_MAX) dir_d = DIR_DOWN; else lvl_d = lvl_q + 1'b1;
        DIR_DOWN: if (lvl_q == '0)      dir_d = DIR_UP;   else lvl_d = lvl_q - 1'b1;
      endcase
    end
  end

  pattern_color #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW),
    .FW       (FW),
    .XW       (XW),
    .YW       (YW)
  ) u_color (
    .i_x     (x_d),
    .i_y     (y_d),
    .i_frame (frame_d),
    .i_lvl   (lvl_d),
    .i_mode  (mode_d),
    .o_rgb   (rgb_d)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      mode_q  <= MODE_GRAD;
      lvl_q   <= '0;
      dir_q   <= DIR_UP;
      rgb_q   <= RGB_RST;
      sof_q   <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      lvl_q   <= lvl_d;
      dir_q   <= dir_d;
      rgb_q   <= rgb_d;
      sof_q   <= sof_d;
    end
  end

  // Enable is sampled even during reset so the blanking tracks i_en there too.
  always_ff @(posedge i_clk) begin
    en_q <= en_d;
  end

  assign o_r     = en_q ? rgb_q[3*CW-1:2*CW] : '0;
  assign o_g     = en_q ? rgb_q[2*CW-1:CW]   : '0;
  assign o_b     = en_q ? rgb_q[CW-1:0]      : '0;
  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_frame = frame_q;
  assign o_sof   = sof_q;
  assign o_mode  = mode_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: directed phases plus randomized handshake,
// checked against a pixel-count based reference model.
module tb_test_pattern_gen;

  localparam int H = 8, V = 4, XS = 2, PPL = H / XS, PPF = PPL * V;

  logic       clk = 1'b0;
  logic       rst, en, rdy;
  logic [2:0] mode_a, mode_b, mode_c;

  logic [5:0] a_r, a_g, a_b;
  logic [2:0] a_x;
  logic [1:0] a_y;
  logic [7:0] a_frame;
  logic       a_sof;
  logic [2:0] a_mode;

  logic [5:0] b_r, b_g, b_b;
  logic [9:0] b_x;
  logic [0:0] b_y;
  logic [7:0] b_frame;
  logic       b_sof;
  logic [2:0] b_mode;

  logic [1:0] c_r, c_g, c_b;
  logic [2:0] c_x;
  logic [1:0] c_y;
  logic [7:0] c_frame;
  logic       c_sof;
  logic [2:0] c_mode;

  test_pattern_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .X_STEP(2), .CW(6), .FW(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode_a), .i_rdy(rdy),
    .o_r(a_r), .o_g(a_g), .o_b(a_b), .o_x(a_x), .o_y(a_y),
    .o_frame(a_frame), .o_sof(a_sof), .o_mode(a_mode));

  test_pattern_gen #(.H_ACTIVE(640), .V_ACTIVE(2), .X_STEP(2), .CW(6), .FW(8)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode_b), .i_rdy(rdy),
    .o_r(b_r), .o_g(b_g), .o_b(b_b), .o_x(b_x), .o_y(b_y),
    .o_frame(b_frame), .o_sof(b_sof), .o_mode(b_mode));

  test_pattern_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .X_STEP(2), .CW(2), .FW(8)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode_c), .i_rdy(rdy),
    .o_r(c_r), .o_g(c_g), .o_b(c_b), .o_x(c_x), .o_y(c_y),
    .o_frame(c_frame), .o_sof(c_sof), .o_mode(c_mode));

  initial forever #5 clk = ~clk;

  int nchk = 0, npass = 0, nfail = 0;
  int adv = 0;
  int mmode = 0;
  bit prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lvl_of(input int wraps, input int cw);
    int top = 1 << cw;
    int p = wraps % (2 * top);
    return (p < top) ? p : (2 * top - 1 - p);
  endfunction

  function automatic logic [17:0] exp_rgb(input int x, input int y, input int frame,
                                          input int lvl, input int mode);
    int r = 0, g = 0, b = 0, bar;
    case (mode)
      0: begin r = 63 - (frame % 64); g = (y + 2 * frame) % 64; b = frame % 64; end
      1: begin r = 63; g = 63; b = 63; end
      2: begin
        bar = (x * 8) / H;
        r = (bar >= 4) ? 63 : 0;
        g = ((bar / 2) % 2 == 1) ? 63 : 0;
        b = (bar % 2 == 1) ? 63 : 0;
      end
      3: if ((x / 32) % 2 != (y / 32) % 2) begin r = 63; g = 63; b = 63; end
      4: begin r = lvl; g = lvl; b = lvl; end
      default: ;
    endcase
    return {6'(r), 6'(g), 6'(b)};
  endfunction

  function automatic int model_x();
    return (adv % PPL) * XS;
  endfunction

  task automatic model_edge();
    if (rst) begin
      adv = 0;
      mmode = 0;
    end else if (en && rdy) begin
      adv++;
      if (adv % PPF == 0) mmode = int'(mode_a);
    end
    prev_en = en;
  endtask

  task automatic check_main();
    int x = model_x();
    int y = (adv / PPL) % V;
    int wraps = adv / PPF;
    logic [17:0] e;
    e = prev_en ? exp_rgb(x, y, wraps % 256, lvl_of(wraps, 6), mmode) : '0;
    chk("x", a_x, x);
    chk("y", a_y, y);
    chk("frame", a_frame, wraps % 256);
    chk("sof", a_sof, (x == 0 && y == 0));
    chk("mode", a_mode, mmode);
    chk("r", a_r, e[17:12]);
    chk("g", a_g, e[11:6]);
    chk("b", a_b, e[5:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_main();
  endtask

  int lseq[8] = '{1, 2, 3, 3, 2, 1, 0, 0};
  int win_left = 0;
  bit win_done = 1'b0;

  initial begin
    rst = 1'b1; en = 1'b1; rdy = 1'b0;
    mode_a = 3'd0; mode_b = 3'd0; mode_c = 3'd4;

    // reset values, colour following enable while held in reset
    repeat (2) tick();
    chk("rst_r_en", a_r, 63);
    en = 1'b0;
    tick();
    chk("rst_r_dis", a_r, 0);
    en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 16 back-to-back pixels: one full frame
    rdy = 1'b1;
    repeat (16) tick();
    chk("f1_frame", a_frame, 1);
    chk("f1_sof", a_sof, 1);
    repeat (36) tick();
    chk("f3_y", a_y, 1);
    chk("f3_r", a_r, 60);
    chk("f3_g", a_g, 7);
    chk("f3_b", a_b, 3);

    // colour bars at 640 wide and bounce level at CW=2, run side by side
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 100) begin
        chk("bars_mode_early", b_mode, 0);
        mode_b = 3'd2;
      end
      if (k == 639) chk("bars_mode_mid", b_mode, 0);
      if (k == 640) begin
        chk("bars_mode_wrap", b_mode, 2);
        chk("bars_x0_r", b_r, 0);
      end
      if (k == 800) begin
        chk("bars_x", b_x, 320);
        chk("bars_r", b_r, 63);
        chk("bars_g", b_g, 0);
        chk("bars_b", b_b, 0);
      end
      if (k % 16 == 0 && k <= 128) begin
        chk("bnc_mode", c_mode, 4);
        chk("bnc_lvl", c_r, lseq[k / 16 - 1]);
        chk("bnc_lvl_b", c_b, lseq[k / 16 - 1]);
      end
    end

    // random ready, random modes, a 5-cycle disable mid-line
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) mode_a = 3'($urandom_range(0, 7));
      if (win_left > 0) begin
        en = 1'b0;
        win_left--;
      end else if (!win_done && i >= 100 && model_x() == 4) begin
        en = 1'b0;
        win_left = 4;
        win_done = 1'b1;
      end else begin
        en = ($urandom_range(0, 30) != 0);
      end
      tick();
    end

    // asynchronous reset at pixel (4,2) of frame 5
    mode_a = 3'd0;
    en = 1'b1;
    rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    repeat (90) tick();
    chk("pre_x", a_x, 4);
    chk("pre_y", a_y, 2);
    chk("pre_frame", a_frame, 5);
    #2;
    rst = 1'b1;
    adv = 0;
    mmode = 0;
    #1;
    check_main();
    chk("async_frame", a_frame, 0);
    chk("async_sof", a_sof, 1);
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rel_x", a_x, 0);
    rdy = 1'b1;
    tick();
    chk("adv_x", a_x, 2);
    chk("adv_frame", a_frame, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
